// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Shares one AXI4 read channel between two read masters (master 0 = icache
// refill, master 1 = dcache refill). One whole burst is granted at a time,
// from the AR handshake through the last R beat. Round-robin on contention.
// A beat counter checks that rlast arrives exactly on beat arlen+1.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   m0_ar*/m1_ar*              master read-address channels
//   m0_r*/m1_r*                master read-data channels (rdata broadcast)
//   s_ar*, s_r*                memory-side AXI read port
//   grant                      index of current/last granted master
//   busy                       high while a burst is in progress (S_AR/S_R)
//   burst_err                  one-cycle pulse on a burst length mismatch
//
// state  | meaning
// S_IDLE | no burst owned; arbitrate between pending requests
// S_AR   | granted master's address passed through to memory
// S_R    | granted master receives data beats until s_rlast is accepted
module axi_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic                  m0_arvalid,
    input  logic [LEN_WIDTH-1:0]  m0_arlen,
    input  logic [2:0]            m0_arsize,
    input  logic [1:0]            m0_arburst,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_rvalid,
    output logic                  m0_rlast,
    input  logic                  m0_rready,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic                  m1_arvalid,
    input  logic [LEN_WIDTH-1:0]  m1_arlen,
    input  logic [2:0]            m1_arsize,
    input  logic [1:0]            m1_arburst,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_rvalid,
    output logic                  m1_rlast,
    input  logic                  m1_rready,
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic                  s_arvalid,
    output logic [LEN_WIDTH-1:0]  s_arlen,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  s_rvalid,
    input  logic                  s_rlast,
    output logic                  s_rready,
    output logic                  grant,
    output logic                  busy,
    output logic                  burst_err
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

    state_t               state;
    logic                 last_winner;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH:0]   beat_cnt;

    logic in_ar;
    logic in_r;
    logic winner;
    logic ar_hs;
    logic r_hs;
    logic last_expected;

    assign in_ar = (state == S_AR);
    assign in_r  = (state == S_R);

    // Contention goes to the master that did not win last time; a lone
    // requester always wins.
    assign winner = (m0_arvalid && m1_arvalid) ? ~last_winner : m1_arvalid;

    // Address channel: granted master passed straight through in S_AR only.
    assign s_arvalid  = in_ar && (grant ? m1_arvalid : m0_arvalid);
    assign s_araddr   = in_ar ? (grant ? m1_araddr  : m0_araddr)  : '0;
    assign s_arlen    = in_ar ? (grant ? m1_arlen   : m0_arlen)   : '0;
    assign s_arsize   = in_ar ? (grant ? m1_arsize  : m0_arsize)  : '0;
    assign s_arburst  = in_ar ? (grant ? m1_arburst : m0_arburst) : '0;
    assign m0_arready = in_ar && !grant && s_arready;
    assign m1_arready = in_ar &&  grant && s_arready;

    // Data channel: memory beats outside S_R are left stalled.
    assign s_rready  = in_r && (grant ? m1_rready : m0_rready);
    assign m0_rvalid = in_r && !grant && s_rvalid;
    assign m1_rvalid = in_r &&  grant && s_rvalid;
    assign m0_rlast  = in_r && !grant && s_rlast;
    assign m1_rlast  = in_r &&  grant && s_rlast;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;

    assign ar_hs = s_arvalid && s_arready;
    assign r_hs  = in_r && s_rvalid && s_rready;

    assign last_expected = (beat_cnt == {1'b0, len_q});
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            grant       <= 1'b0;
            last_winner <= 1'b1;
            len_q       <= '0;
            beat_cnt    <= '0;
            burst_err   <= 1'b0;
        end else begin
            burst_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (m0_arvalid || m1_arvalid) begin
                        grant       <= winner;
                        last_winner <= winner;
                        state       <= S_AR;
                    end
                end
                S_AR: begin
                    if (ar_hs) begin
                        len_q    <= s_arlen;
                        beat_cnt <= '0;
                        state    <= S_R;
                    end
                end
                S_R: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        // Flag rlast early/late; the burst still ends on rlast.
                        if (s_rlast != last_expected)
                            burst_err <= 1'b1;
                        if (s_rlast)
                            state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AXI4 read channel to external memory between two read masters: master 0 = icache refill, master 1 = dcache refill.
- Sits between the two cache controllers and the memory-side AXI read port.
- Grants one whole burst at a time: AR handshake through the last R beat.
- Round-robin on contention; checks burst length integrity.

Parameters:
ADDR_WIDTH, 32, address width of all AR channels
DATA_WIDTH, 32, data width of all R channels
LEN_WIDTH, 8, arlen width (AXI4)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
m0_araddr / m1_araddr  in  ADDR_WIDTH  master read address
m0_arvalid / m1_arvalid  in  1  master address valid
m0_arlen / m1_arlen  in  LEN_WIDTH  master burst length minus 1
m0_arsize / m1_arsize  in  3  master beat size
m0_arburst / m1_arburst  in  2  master burst type
m0_arready / m1_arready  out  1  address accepted
m0_rdata / m1_rdata  out  DATA_WIDTH  read data (broadcast of s_rdata)
m0_rvalid / m1_rvalid  out  1  beat valid, granted master only
m0_rlast / m1_rlast  out  1  last beat, granted master only
m0_rready / m1_rready  in  1  master data ready
s_araddr  out  ADDR_WIDTH  memory-side address
s_arvalid  out  1  memory-side address valid
s_arlen  out  LEN_WIDTH  memory-side burst length
s_arsize  out  3  memory-side beat size
s_arburst  out  2  memory-side burst type
s_arready  in  1  memory accepts address
s_rdata  in  DATA_WIDTH  memory read data
s_rvalid  in  1  memory beat valid
s_rlast  in  1  memory last beat
s_rready  out  1  ready toward memory
grant  out  1  index of current/last granted master
busy  out  1  high in S_AR or S_R
burst_err  out  1  one-cycle pulse on burst length mismatch

Behaviour:
- FSM states:
  - S_IDLE: if any mX_arvalid, latch winner into grant, go to S_AR.
  - S_AR: go to S_R on s_arvalid && s_arready.
  - S_R: go to S_IDLE on s_rvalid && s_rready && s_rlast.
- Arbitration (S_IDLE only):
  - Single requester wins.
  - Both requesting: master != last_winner wins.
  - last_winner resets to 1, so master 0 wins the first tie.
  - last_winner updates on S_IDLE->S_AR.
- Latency: arvalid seen in cycle N (S_IDLE) -> s_arvalid high in cycle N+1. Zero-cycle combinational pass-through thereafter.
- S_AR:
  - s_ar* = granted master's ar* fields.
  - s_arvalid = granted mX_arvalid.
  - Granted mX_arready = s_arready.
  - Other master's arready = 0.
  - If the granted master deasserts arvalid, the grant is held and s_arvalid = 0.
- S_AR handshake:
  - arlen latched into len_q.
  - beat counter cleared.
- S_R:
  - s_rready = granted mX_rready.
  - Granted mX_rvalid/rlast = s_rvalid/s_rlast.
  - Non-granted rvalid/rlast = 0.
  - rdata broadcast to both masters.
- Outside S_AR/S_R: s_arvalid, s_rready, all mX_arready/rvalid/rlast = 0. s_araddr/len/size/burst = 0 in S_IDLE.
- Beat counter (LEN_WIDTH+1 bits): increments on each R handshake in S_R.
- burst_err pulses for one cycle, registered, in the cycle after either condition:
  - A handshake with s_rlast where counter != len_q.
  - A handshake without s_rlast where counter == len_q.
  - On an early/late rlast, the FSM still follows s_rlast.
- Memory beats in S_IDLE/S_AR are ignored (s_rready = 0). Non-granted requests stay pending, unacknowledged.
- busy = (state != S_IDLE). grant holds its value in S_IDLE.
- Reset (asynchronous, any time, incl. mid-burst):
  - State -> S_IDLE; grant = 0, last_winner = 1.
  - Counter, len_q = 0; burst_err = 0; busy = 0.
  - All handshake outputs 0 immediately.
  - No recovery of the interrupted burst.

Test Plan:
- Single icache request: m0 araddr=0x0000_1000, arlen=7; s_arready at cycle 3; 8 beats 0xA0..0xA7 with rlast on 8th.
  -> s_araddr=0x1000, s_arlen=7; m0 gets 8 rvalid beats with rdata 0xA0..0xA7 and m0_rlast on the 8th; m1_rvalid stays 0; burst_err=0; busy drops the cycle after rlast.
- Simultaneous m0 and m1 arvalid after reset -> m0 served first (grant=0); then m1 served (grant=1) with no idle gap beyond one S_IDLE cycle. A third tie -> m0.
- m1 requests during an m0 burst -> m1_arready stays 0 until m0 rlast accepted; s_araddr = m1 address one cycle later.
- rlast asserted on 6th beat of arlen=7 burst -> burst_err pulses once; FSM returns to S_IDLE.
- Separately, 8th beat without rlast -> burst_err pulses.
- Master backpressure: m0_rready low for 3 cycles mid-burst -> s_rready low, beat counter holds, data order preserved.
- rst_n asserted at beat 4 -> all valids/readys 0 immediately; busy=0; grant=0. The next m1 request is granted normally.
